fib_scheduler: RTL and testbench

//   Shares one fibonacci engine among NREQ requesters using round-robin arbitration.
//   - Accepts one request, pulses the engine's start with the request's N, and waits for done.
//   - Returns the engine result, tagged with the requester id, on a shared response channel.
//   - A watchdog aborts a hung computation, resets the engine and returns an error response.

---
 rtl/fib_scheduler_if.sv | 34 +++
 rtl/fib_scheduler.sv | 121 ++++++++++++
 tb/tb_fib_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_scheduler_if.sv
// Bundles the requester, response and engine buses of fib_scheduler.
// Ports: req_valid/req_n/req_ready (requesters), resp_* (shared response channel),
//        fib_start/fib_din/fib_dout/fib_done/fib_rst (fibonacci engine).
// master = scheduler side, slave = requesters/consumer/engine side.
interface fib_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DW-1:0]      req_n;
  logic [NREQ-1:0]         req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [$clog2(NREQ)-1:0] resp_id;
  logic [DW-1:0]           resp_data;
  logic                    resp_err;
  logic                    fib_start;
  logic [DW-1:0]           fib_din;
  logic [DW-1:0]           fib_dout;
  logic                    fib_done;
  logic                    fib_rst;

  modport master (
    input  req_valid, req_n, resp_ready, fib_dout, fib_done,
    output req_ready, resp_valid, resp_id, resp_data, resp_err,
           fib_start, fib_din, fib_rst
  );

  modport slave (
    output req_valid, req_n, resp_ready, fib_dout, fib_done,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err,
           fib_start, fib_din, fib_rst
  );
endinterface

// File: rtl/fib_scheduler.sv
// Purpose: round-robin share of one fibonacci engine among NREQ requesters, with watchdog abort.
// Latency: accept -> resp_valid = 2 + engine latency cycles (TIMEOUT + 2 on abort).
// Backpressure: response held stable until resp_ready; no new grant until the handshake completes.
// Ports: clk, reset (sync, active-high); bus = fib_scheduler_if.master carrying the
//        requester, response and engine signals.
module fib_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  fib_scheduler_if.master   bus
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   id_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   din_q;
  logic [DW-1:0]   data_q;
  logic            err_q;
  logic            resp_vld_q;
  logic            start_q;
  logic            abort_q;
  logic            rst_dly_q;   // high for the first cycle after reset; blocks grants then

  // Round-robin pick: scan ptr, ptr+1, ... and keep the nearest set bit.
  // Iterating from the far end lets the closest candidate overwrite the rest.
  logic            win_vld;
  logic [IW-1:0]   win_id;
  logic [IW:0]     idx;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (bus.req_valid[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[IW-1:0];
      end
    end
  end

  logic grant;
  assign grant         = (state_q == S_IDLE) && !reset && !rst_dly_q && win_vld;
  assign bus.req_ready = grant ? (NREQ'(1) << win_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      timer_q    <= '0;
      din_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      resp_vld_q <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      rst_dly_q  <= 1'b1;
    end else begin
      rst_dly_q <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            id_q    <= win_id;
            din_q   <= bus.req_n[int'(win_id) * DW +: DW];
            start_q <= 1'b1;          // start pulse lands in the ISSUE cycle
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          // done has priority over an expiry in the same cycle
          if (bus.fib_done) begin
            data_q     <= bus.fib_dout;
            err_q      <= 1'b0;
            resp_vld_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            data_q     <= '0;
            err_q      <= 1'b1;
            abort_q    <= 1'b1;       // engine reset during the first RESP cycle
            resp_vld_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_vld_q <= 1'b0;
            ptr_q      <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign bus.fib_start  = start_q;
  assign bus.fib_din    = din_q;
  assign bus.fib_rst    = reset | abort_q;
endmodule

// File: tb/tb_fib_scheduler.sv
// Testbench for fib_scheduler: stub engine with programmable latency/hang,
// directed scenarios plus a randomized run against a round-robin/fibonacci reference model.
module tb_fib_scheduler;
  localparam int NREQ = 4;
  localparam int DW = 16;
  localparam int TIMEOUT = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fib_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();
  fib_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fib_ref(input logic [DW-1:0] n);
    logic [DW-1:0] a, b, t;
    a = '0; b = 1;
    for (int i = 0; i < int'(n); i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  // Stub engine: done pulses in WAIT cycle eng_lat after the start pulse; eng_hang never completes.
  int eng_lat = 0;
  bit eng_hang = 0;
  logic eng_busy;
  int eng_cnt;
  logic [DW-1:0] eng_n;
  always @(posedge clk) begin
    if (bus.fib_rst) begin
      eng_busy <= 1'b0; bus.fib_done <= 1'b0; bus.fib_dout <= '0;
    end else begin
      bus.fib_done <= 1'b0;
      if (bus.fib_start) begin
        eng_n <= bus.fib_din; eng_cnt <= eng_lat;
        if (!eng_hang && eng_lat == 0) begin
          bus.fib_done <= 1'b1; bus.fib_dout <= fib_ref(bus.fib_din); eng_busy <= 1'b0;
        end else eng_busy <= !eng_hang;
      end else if (eng_busy) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          bus.fib_done <= 1'b1; bus.fib_dout <= fib_ref(eng_n); eng_busy <= 1'b0;
        end
      end
    end
  end

  // Event records filled by run_collect
  int acc_id[$], acc_cyc[$], st_cyc[$], st_din[$], dn_cyc[$], rst_cyc[$], rv_cyc[$], hs_cyc[$];
  int rs_id[$];
  logic [DW-1:0] rs_data[$];
  logic rs_err[$];
  int viol, chg, bp_cycles = 0;

  task automatic clear_rec();
    acc_id.delete(); acc_cyc.delete(); st_cyc.delete(); st_din.delete(); dn_cyc.delete();
    rst_cyc.delete(); rv_cyc.delete(); hs_cyc.delete(); rs_id.delete(); rs_data.delete(); rs_err.delete();
    viol = 0; chg = 0;
  endtask

  // Runs until nresp response handshakes are seen; ends at the negedge of the last handshake cycle.
  task automatic run_collect(input int nresp, input int max_cyc, output bit ok);
    int got, rvlen;
    logic [NREQ-1:0] drop;
    logic pv, pe;
    logic [IW-1:0] pid;
    logic [DW-1:0] pd;
    got = 0; rvlen = 0; ok = 0; pv = 0; pe = 0; pid = '0; pd = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      bus.resp_ready = bus.resp_valid ? (rvlen >= bp_cycles) : 1'b1;
      drop = bus.req_ready;
      if (bus.req_ready != 0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) acc_id.push_back(i);
        acc_cyc.push_back(cyc);
      end
      if (bus.fib_start) begin st_cyc.push_back(cyc); st_din.push_back(int'(bus.fib_din)); end
      if (bus.fib_done) dn_cyc.push_back(cyc);
      if (bus.fib_rst) rst_cyc.push_back(cyc);
      if (bus.resp_valid) begin
        if (bus.req_ready != 0) viol++;
        if (!pv) rv_cyc.push_back(cyc);
        else if (pid !== bus.resp_id || pd !== bus.resp_data || pe !== bus.resp_err) chg++;
        rvlen++;
        if (bus.resp_ready) begin
          rs_id.push_back(int'(bus.resp_id)); rs_data.push_back(bus.resp_data); rs_err.push_back(bus.resp_err);
          hs_cyc.push_back(cyc); got++; rvlen = 0; pv = 0;
        end else begin
          pv = 1; pid = bus.resp_id; pd = bus.resp_data; pe = bus.resp_err;
        end
      end else begin
        rvlen = 0; pv = 0;
      end
      if (got == nresp) begin ok = 1; break; end
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~drop;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req_valid = '0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req_valid = '1; bus.req_n = {$urandom, $urandom}; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL rst_resp_id: got %0d want 0", bus.resp_id); end
    n_tests++; if (bus.resp_data !== 16'd0) begin n_fail++; $display("FAIL rst_resp_data: got %0d want 0", bus.resp_data); end
    n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_tests++; if (bus.fib_start !== 1'b0) begin n_fail++; $display("FAIL rst_fib_start: got %b want 0", bus.fib_start); end
    n_tests++; if (bus.fib_din !== 16'd0) begin n_fail++; $display("FAIL rst_fib_din: got %0d want 0", bus.fib_din); end
    n_tests++; if (bus.fib_rst !== 1'b1) begin n_fail++; $display("FAIL rst_fib_rst: got %b want 1", bus.fib_rst); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 0000", bus.req_ready); end
    n_tests++; if (bus.fib_rst !== 1'b0) begin n_fail++; $display("FAIL post_rst_fib_rst: got %b want 0", bus.fib_rst); end
    n_tests++; if (bus.resp_valid !== 1'b0 || bus.fib_start !== 1'b0) begin n_fail++; $display("FAIL post_rst_outs: got valid=%b start=%b want 0 0", bus.resp_valid, bus.fib_start); end
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_grant: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    n_tests++; if (bus.fib_start !== 1'b0) begin n_fail++; $display("FAIL withdrawn_start: got %b want 0", bus.fib_start); end
  endtask

  task automatic test_single();
    bit ok;
    clear_rec(); eng_hang = 0; eng_lat = 3; bp_cycles = 0;
    @(posedge clk); #1;
    bus.req_n[0 +: DW] = 16'd5; bus.req_valid = 4'b0001;
    run_collect(1, 60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no response want 1"); end
    if (ok) begin
      n_tests++; if (acc_id.size() != 1 || acc_id[0] != 0) begin n_fail++; $display("FAIL single_accept: got n=%0d want one grant to id0", acc_id.size()); end
      n_tests++; if (st_cyc.size() != 1 || st_din[0] != 5) begin n_fail++; $display("FAIL single_start: got pulses=%0d want 1 with din 5", st_cyc.size()); end
      n_tests++; if (st_cyc[0] != acc_cyc[0] + 1) begin n_fail++; $display("FAIL single_start_cyc: got %0d want %0d", st_cyc[0], acc_cyc[0] + 1); end
      n_tests++; if (rs_id[0] != 0 || rs_data[0] !== 16'd5 || rs_err[0] !== 1'b0) begin n_fail++; $display("FAIL single_resp: got id=%0d data=%0d err=%b want 0 5 0", rs_id[0], rs_data[0], rs_err[0]); end
      n_tests++; if (rv_cyc[0] - acc_cyc[0] != 2 + (dn_cyc[0] - st_cyc[0])) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", rv_cyc[0] - acc_cyc[0], 2 + (dn_cyc[0] - st_cyc[0])); end
    end
  endtask

  task automatic test_all_four();
    bit ok;
    logic [DW-1:0] exp_d[4];
    exp_d[0] = 2; exp_d[1] = 3; exp_d[2] = 5; exp_d[3] = 8;
    do_reset(); clear_rec(); eng_lat = 1;
    bus.req_n = {16'd6, 16'd5, 16'd4, 16'd3}; bus.req_valid = 4'b1111;
    run_collect(4, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL four_timeout: got %0d responses want 4", rs_id.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (rs_id[i] != i || rs_data[i] !== exp_d[i] || rs_err[i] !== 1'b0) begin n_fail++; $display("FAIL four_resp%0d: got id=%0d data=%0d err=%b want %0d %0d 0", i, rs_id[i], rs_data[i], rs_err[i], i, exp_d[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (acc_cyc[i+1] != hs_cyc[i] + 1) begin n_fail++; $display("FAIL four_regrant%0d: got cyc %0d want %0d", i, acc_cyc[i+1], hs_cyc[i] + 1); end
      end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL four_ready_in_resp: got %0d want 0", viol); end
    end
  endtask

  task automatic test_round_robin();
    bit ok1, ok2;
    int eid[3];
    logic [DW-1:0] ed[3];
    eid[0] = 2; eid[1] = 3; eid[2] = 0; ed[0] = 13; ed[1] = 34; ed[2] = 21;
    clear_rec(); eng_lat = 0;
    @(posedge clk); #1;
    bus.req_n[2*DW +: DW] = 16'd7; bus.req_valid = 4'b0100;
    run_collect(1, 60, ok1);
    @(posedge clk); #1;
    bus.req_n[0 +: DW] = 16'd8; bus.req_n[3*DW +: DW] = 16'd9; bus.req_valid = 4'b1001;
    run_collect(2, 100, ok2);
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL rr_timeout: got %0d responses want 3", rs_id.size()); end
    if (ok1 && ok2) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (rs_id[i] != eid[i] || rs_data[i] !== ed[i]) begin n_fail++; $display("FAIL rr_order%0d: got id=%0d data=%0d want %0d %0d", i, rs_id[i], rs_data[i], eid[i], ed[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_rec(); eng_hang = 1; bp_cycles = 2;
    @(posedge clk); #1;
    bus.req_n[DW +: DW] = 16'd7; bus.req_valid = 4'b0010;
    run_collect(1, 80, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_noresp: got no response want 1"); end
    if (ok) begin
      n_tests++; if (rs_id[0] != 1 || rs_err[0] !== 1'b1 || rs_data[0] !== 16'd0) begin n_fail++; $display("FAIL to_resp: got id=%0d data=%0d err=%b want 1 0 1", rs_id[0], rs_data[0], rs_err[0]); end
      n_tests++; if (rv_cyc[0] - acc_cyc[0] != TIMEOUT + 2) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", rv_cyc[0] - acc_cyc[0], TIMEOUT + 2); end
      n_tests++; if (rst_cyc.size() != 1) begin n_fail++; $display("FAIL to_rst_len: got %0d cycles want 1", rst_cyc.size()); end
      n_tests++; if (rst_cyc.size() == 0 || rst_cyc[0] != rv_cyc[0]) begin n_fail++; $display("FAIL to_rst_cyc: got n=%0d want pulse at cyc %0d", rst_cyc.size(), rv_cyc[0]); end
    end
    eng_hang = 0; bp_cycles = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_rec(); eng_lat = 2; bp_cycles = 10;
    @(posedge clk); #1;
    bus.req_n[2*DW +: DW] = 16'd10; bus.req_n[3*DW +: DW] = 16'd4; bus.req_valid = 4'b1100;
    run_collect(2, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d responses want 2", rs_id.size()); end
    if (ok) begin
      n_tests++; if (rs_id[0] != 2 || rs_data[0] !== 16'd55 || rs_err[0] !== 1'b0) begin n_fail++; $display("FAIL bp_resp0: got id=%0d data=%0d err=%b want 2 55 0", rs_id[0], rs_data[0], rs_err[0]); end
      n_tests++; if (chg != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", chg); end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL bp_no_grant: got %0d want 0", viol); end
      n_tests++; if (hs_cyc[0] - rv_cyc[0] != 10) begin n_fail++; $display("FAIL bp_hold: got %0d want 10", hs_cyc[0] - rv_cyc[0]); end
      n_tests++; if (acc_cyc[1] != hs_cyc[0] + 1) begin n_fail++; $display("FAIL bp_idle: got cyc %0d want %0d", acc_cyc[1], hs_cyc[0] + 1); end
      n_tests++; if (rs_id[1] != 3 || rs_data[1] !== 16'd3) begin n_fail++; $display("FAIL bp_resp1: got id=%0d data=%0d want 3 3", rs_id[1], rs_data[1]); end
    end
    bp_cycles = 0;
  endtask

  task automatic test_reset_wait();
    bit ok1, ok, got;
    int nseen;
    clear_rec(); eng_lat = 0;
    @(posedge clk); #1;
    bus.req_n[DW +: DW] = 16'd2; bus.req_valid = 4'b0010;
    run_collect(1, 60, ok1);            // leaves the pointer at 2
    eng_lat = 20;
    @(posedge clk); #1;
    bus.req_n[2*DW +: DW] = 16'd9; bus.req_valid = 4'b0100;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin got = 1; break; end
    end
    n_tests++; if (!(ok1 && got)) begin n_fail++; $display("FAIL rw_setup: got ok=%b grant=%b want 1 1", ok1, got); end
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.fib_rst !== 1'b1) begin n_fail++; $display("FAIL rw_fib_rst: got %b want 1", bus.fib_rst); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'd0 || bus.resp_err !== 1'b0 || bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL rw_resp_clear: got v=%b d=%0d e=%b id=%0d want all 0", bus.resp_valid, bus.resp_data, bus.resp_err, bus.resp_id); end
    n_tests++; if (bus.fib_start !== 1'b0 || bus.fib_din !== 16'd0 || bus.fib_rst !== 1'b0 || bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rw_eng_clear: got s=%b din=%0d rst=%b rdy=%b want all 0", bus.fib_start, bus.fib_din, bus.fib_rst, bus.req_ready); end
    nseen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.resp_valid) nseen++;
    end
    n_tests++; if (nseen != 0) begin n_fail++; $display("FAIL rw_no_resp: got %0d valid cycles want 0", nseen); end
    clear_rec(); eng_lat = 1;
    @(posedge clk); #1;
    bus.req_n[DW +: DW] = 16'd1; bus.req_n[3*DW +: DW] = 16'd1; bus.req_valid = 4'b1010;
    run_collect(1, 60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rw_after_noresp: got no response want 1"); end
    if (ok) begin
      n_tests++; if (rs_id[0] != 1 || rs_data[0] !== 16'd1 || rs_err[0] !== 1'b0) begin n_fail++; $display("FAIL rw_after_resp: got id=%0d data=%0d err=%b want 1 1 0", rs_id[0], rs_data[0], rs_err[0]); end
    end
  endtask

  task automatic test_random();
    bit pend[NREQ];
    logic [DW-1:0] pn[NREQ];
    int wgt[NREQ];
    int m_ptr, pick, served, eid;
    int exp_id[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] ed;
    logic [NREQ-1:0] exp_rdy;
    bit idle_ok, fin;
    do_reset(); eng_hang = 0; bp_cycles = 0;
    m_ptr = 0; served = 0; idle_ok = 1; fin = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pn[i] = '0; wgt[i] = 0; end
    for (int c = 0; c < 2600 && !fin; c++) begin
      @(negedge clk);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      pick = -1;
      for (int k = NREQ - 1; k >= 0; k--) if (pend[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      if (idle_ok && pick >= 0) exp_rdy[pick] = 1'b1;
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, bus.req_ready, exp_rdy); end
      if (idle_ok && pick >= 0) begin
        n_tests++; if (wgt[pick] >= NREQ) begin n_fail++; $display("FAIL rnd_fair: got %0d grants ahead of id%0d want <%0d", wgt[pick], pick, NREQ); end
        for (int i = 0; i < NREQ; i++) if (pend[i] && i != pick) wgt[i]++;
        exp_id.push_back(pick); exp_d.push_back(fib_ref(pn[pick]));
        pend[pick] = 0; wgt[pick] = 0; idle_ok = 0;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        n_tests++;
        if (exp_id.size() == 0) begin n_fail++; $display("FAIL rnd_spurious: got id=%0d want no response", bus.resp_id); end
        else begin
          eid = exp_id.pop_front(); ed = exp_d.pop_front();
          if (bus.resp_id !== IW'(eid) || bus.resp_data !== ed || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rnd_resp: got id=%0d data=%0d err=%b want %0d %0d 0", bus.resp_id, bus.resp_data, bus.resp_err, eid, ed); end
          m_ptr = (eid + 1) % NREQ;
        end
        idle_ok = 1; served++;
      end
      if (c >= 2000 && exp_id.size() == 0 && idle_ok && !(pend[0] || pend[1] || pend[2] || pend[3])) fin = 1;
      @(posedge clk); #1;
      if (c < 2000) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 5) == 0) begin pend[i] = 1; pn[i] = DW'($urandom_range(0, 24)); end
        end
      end
      for (int i = 0; i < NREQ; i++) begin bus.req_valid[i] = pend[i]; bus.req_n[i*DW +: DW] = pn[i]; end
      eng_lat = $urandom_range(0, 4);
    end
    n_tests++; if (!fin) begin n_fail++; $display("FAIL rnd_drain: got %0d outstanding want 0", exp_id.size()); end
    n_tests++; if (served < 50) begin n_fail++; $display("FAIL rnd_throughput: got %0d served want >=50", served); end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_n = '0; bus.resp_ready = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test want finish before 1ms");
    $fatal(1, "simulation time limit");
  end
endmodule
